// File: rtl/mult.sv
// Iterative signed 32x32 radix-2 Booth multiplier, one iteration per clock.
// Latency: 32 cycles from start edge to multStop pulse; all outputs registered.
// No backpressure: multControl restarts at any time, aborting any operation in flight.
module mult (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        multControl,
    output logic        multStop,
    output logic        multBusy,
    output logic [31:0] hiMult,
    output logic [31:0] loMult
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // A and M are 33 bits so A-M cannot overflow even for a = 0x80000000.
    logic [32:0] acc;
    logic [32:0] mcand;
    logic [31:0] q;
    logic        q_1;
    logic [5:0]  count;

    logic [32:0]        addsub;
    logic signed [65:0] shifted;
    logic [32:0]        acc_next;
    logic [31:0]        q_next;
    logic               q_1_next;
    logic               last_iter;

    // One Booth step: add/subtract per {Q[0],q_1}, then arithmetic shift of {A,Q,q_1}.
    always_comb begin
        addsub = acc;
        case ({q[0], q_1})
            2'b01:   addsub = acc + mcand;
            2'b10:   addsub = acc - mcand;
            default: addsub = acc;
        endcase
        shifted   = $signed({addsub, q, q_1}) >>> 1;
        acc_next  = shifted[65:33];
        q_next    = shifted[32:1];
        q_1_next  = shifted[0];
        last_iter = (state == RUN) && (count == 6'd1);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start request wins from every state.
    always_comb begin
        state_next = state;
        if (multControl) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:     state_next = last_iter ? DONE : RUN;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc      <= '0;
            mcand    <= '0;
            q        <= '0;
            q_1      <= 1'b0;
            count    <= '0;
            hiMult   <= '0;
            loMult   <= '0;
            multStop <= 1'b0;
            multBusy <= 1'b0;
        end else if (multControl) begin
            acc      <= '0;
            mcand    <= {a[31], a};
            q        <= b;
            q_1      <= 1'b0;
            count    <= 6'd32;
            hiMult   <= '0;
            loMult   <= '0;
            multStop <= 1'b0;
            multBusy <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    acc   <= acc_next;
                    q     <= q_next;
                    q_1   <= q_1_next;
                    count <= count - 6'd1;
                    if (last_iter) begin
                        hiMult   <= acc_next[31:0];
                        loMult   <= q_next;
                        multStop <= 1'b1;
                        multBusy <= 1'b0;
                    end
                end
                DONE: begin
                    multStop <= 1'b0;
                end
                default: begin
                    multStop <= 1'b0;
                    multBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult.sv
// Bench for mult: directed cases, abort/restart, mid-run reset and randomized
// back-to-back operations checked against a 64-bit signed product.
// Inputs change #1 after a rising edge; outputs are sampled at the same point.
module tb_mult;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        multControl;
    logic        multStop;
    logic        multBusy;
    logic [31:0] hiMult;
    logic [31:0] loMult;

    int checks = 0;
    int errors = 0;

    logic [31:0] last_hi;
    logic [31:0] last_lo;

    mult dut (
        .clk         (clk),
        .reset       (reset),
        .a           (a),
        .b           (b),
        .multControl (multControl),
        .multStop    (multStop),
        .multBusy    (multBusy),
        .hiMult      (hiMult),
        .loMult      (loMult)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
    endfunction

    // Present a start request for exactly one rising edge, then scramble the operands.
    task automatic launch(input logic [31:0] x, input logic [31:0] y);
        a = x;
        b = y;
        multControl = 1'b1;
        @(posedge clk);
        #1;
        multControl = 1'b0;
        a = $urandom;
        b = $urandom;
        check("busy_after_start", {63'd0, multBusy}, 64'd1);
        check("stop_after_start", {63'd0, multStop}, 64'd0);
    endtask

    // Wait (bounded) for multStop; require 32-cycle latency and the exact product.
    task automatic await_result(input string tag, input logic [31:0] x, input logic [31:0] y);
        int n;
        logic [63:0] p;
        bit busy_ok;
        p = ref_product(x, y);
        n = 0;
        busy_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            n = i;
            if (multStop) break;
            if (!multBusy) busy_ok = 1'b0;
            if (i == 40) n = 41;
        end
        check({tag, "_latency"}, 64'(n), 64'd32);
        check({tag, "_busy_during_run"}, {63'd0, busy_ok}, 64'd1);
        check({tag, "_product"}, {hiMult, loMult}, p);
        check({tag, "_busy_at_done"}, {63'd0, multBusy}, 64'd0);
        last_hi = p[63:32];
        last_lo = p[31:0];
    endtask

    // One idle cycle after DONE: pulse must have fallen, results must hold.
    task automatic idle_after_done(input string tag);
        @(posedge clk);
        #1;
        check({tag, "_stop_fell"}, {63'd0, multStop}, 64'd0);
        check({tag, "_held"}, {hiMult, loMult}, {last_hi, last_lo});
    endtask

    task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] exp);
        launch(x, y);
        await_result(tag, x, y);
        check({tag, "_table"}, {hiMult, loMult}, exp);
        idle_after_done(tag);
    endtask

    initial begin
        bit seen_stop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [31:0] na;
        logic [31:0] nb;
        int gap;

        reset = 1'b0;
        a = '0;
        b = '0;
        multControl = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {hiMult, loMult}, 64'd0);
        check("reset_stop_busy", {62'd0, multStop, multBusy}, 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("idle_busy", {63'd0, multBusy}, 64'd0);

        // Directed products.
        directed("7x6",       32'd7,          32'd6,          64'h00000000_0000002A);
        directed("m3x5",      32'hFFFFFFFD,   32'd5,          64'hFFFFFFFF_FFFFFFF1);
        directed("m1xm1",     32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001);
        directed("minxmin",   32'h80000000,   32'h80000000,   64'h40000000_00000000);
        directed("maxxmax",   32'h7FFFFFFF,   32'h7FFFFFFF,   64'h3FFFFFFF_00000001);
        directed("minx1",     32'h80000000,   32'd1,          64'hFFFFFFFF_80000000);
        directed("0x0",       32'd0,          32'd0,          64'h0);

        // Abort and restart 10 cycles in: only the second operation completes.
        launch(32'd3, 32'd4);
        seen_stop = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
            if (multStop) seen_stop = 1'b1;
        end
        launch(32'd9, 32'd9);
        await_result("restart", 32'd9, 32'd9);
        check("restart_product", {hiMult, loMult}, 64'h51);
        check("restart_no_early_stop", {63'd0, seen_stop}, 64'd0);
        idle_after_done("restart");

        // Reset mid-run, with start requests held during reset.
        launch(32'd5, 32'd5);
        repeat (15) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("midreset_outputs", {hiMult, loMult}, 64'd0);
        check("midreset_stop_busy", {62'd0, multStop, multBusy}, 64'd0);
        multControl = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ignores_start", {62'd0, multStop, multBusy}, 64'd0);
        multControl = 1'b0;
        reset = 1'b1;
        seen_stop = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (multStop || multBusy) seen_stop = 1'b1;
        end
        check("no_stop_after_reset", {63'd0, seen_stop}, 64'd0);
        launch(32'd2, 32'd3);
        await_result("post_reset", 32'd2, 32'd3);
        check("post_reset_product", {hiMult, loMult}, 64'd6);
        idle_after_done("post_reset");

        // Random regression with back-to-back and DONE-cycle starts.
        ra = $urandom;
        rb = $urandom;
        launch(ra, rb);
        for (int k = 0; k < 1400; k++) begin
            await_result("rand", ra, rb);
            case ($urandom_range(0, 7))
                0: na = 32'h80000000;
                1: na = 32'h7FFFFFFF;
                2: na = 32'hFFFFFFFF;
                3: na = 32'($urandom_range(0, 15));
                default: na = $urandom;
            endcase
            nb = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
            ra = na;
            rb = nb;
            gap = $urandom_range(0, 2);
            if (gap == 0) begin
                // Start lands on the DONE-cycle edge; the pulse must still fall.
                launch(ra, rb);
            end else begin
                idle_after_done("rand");
                repeat (gap - 1) @(posedge clk);
                #0;
                launch(ra, rb);
            end
        end
        await_result("rand_last", ra, rb);
        idle_after_done("rand_last");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
